// File: rtl/rejestr_wyniku.sv
// Output stage of the arithmetic unit: captures the bit-set stage result on a
// valid/ready handshake, holds it in a 2-entry skid buffer with derived status
// flags, and keeps a saturating count of erroneous results.
module rejestr_wyniku #(
    parameter int unsigned BITS     = 32,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [BITS-1:0]     i_result,
    input  logic                i_error,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [BITS-1:0]     o_result,
    output logic [3:0]          o_status,
    output logic [CNT_BITS-1:0] o_err_cnt
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // State value equals buffer occupancy
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t          state;
    logic [BITS-1:0] tail_result;
    logic [3:0]      tail_status;

    logic            push_c;
    logic            pop_c;
    logic [BITS-1:0] new_result_c;
    logic [3:0]      new_status_c;

    // Handshake decode and status of the incoming entry; errors store zero
    always_comb begin
        push_c       = i_valid && o_ready;
        pop_c        = o_valid && i_ready;
        new_result_c = i_error ? '0 : i_result;
        new_status_c = {^new_result_c, (new_result_c == '0), new_result_c[BITS-1], i_error};
    end

    // Skid buffer FSM, registered handshake outputs and error counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= EMPTY;
            o_valid     <= 1'b0;
            o_ready     <= 1'b1;
            o_result    <= '0;
            o_status    <= 4'b0000;
            tail_result <= '0;
            tail_status <= 4'b0000;
            o_err_cnt   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push_c) begin
                        o_result <= new_result_c;
                        o_status <= new_status_c;
                        o_valid  <= 1'b1;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (push_c && pop_c) begin
                        // head leaves, incoming entry takes its place
                        o_result <= new_result_c;
                        o_status <= new_status_c;
                    end else if (push_c) begin
                        tail_result <= new_result_c;
                        tail_status <= new_status_c;
                        o_ready     <= 1'b0;
                        state       <= FULL;
                    end else if (pop_c) begin
                        o_valid <= 1'b0;
                        state   <= EMPTY;
                    end
                end
                FULL: begin
                    // no push possible here since o_ready is low
                    if (pop_c) begin
                        o_result <= tail_result;
                        o_status <= tail_status;
                        o_ready  <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= EMPTY;
                end
            endcase

            if (push_c && i_error && (o_err_cnt != CNT_MAX)) begin
                o_err_cnt <= o_err_cnt + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: doc/rejestr_wyniku.md
# rejestr_wyniku

Synchronous output stage of the arithmetic unit. It sits directly downstream of the combinational bit-set stage (`ustawienie`) and captures that stage's `o_result` and `o_error` on a valid/ready handshake. It holds each capture in a 2-entry skid buffer and presents it to the consumer with derived status flags. It also keeps a saturating count of erroneous results for diagnostics.

## Interface
Parameters:
- BITS, 32, data width; matches the upstream stage's `BITS`.
- CNT_BITS, 8, width of the error counter.

Ports:
- i_clk  input  1  single clock; all state updates on the rising edge.
- i_rst  input  1  reset, synchronous and active-high.
- i_valid  input  1  upstream presents a result this cycle.
- o_ready  output  1  buffer can accept; registered, equals (occupancy < 2).
- i_result  input  BITS  upstream result (`o_result` of the bit-set stage).
- i_error  input  1  upstream error flag (`o_error` of the bit-set stage).
- o_valid  output  1  head entry available.
- i_ready  input  1  downstream accepts the head this cycle.
- o_result  output  BITS  head result.
- o_status  output  4  head flags: [0] ERR, [1] NEG, [2] ZERO, [3] PAR.
- o_err_cnt  output  CNT_BITS  saturating count of accepted entries with ERR=1.

## Operation
- Push: occurs when i_valid && o_ready at a clock edge. Pop: occurs when o_valid && i_ready at a clock edge.
- Stored result on push:
  - i_error=1: store '0.
  - i_error=0: store i_result.
- Status is computed at push time and stored with the entry:
  - ERR = i_error.
  - NEG = stored result[BITS-1].
  - ZERO = (stored result == '0). An error entry therefore has ZERO=1.
  - PAR = XOR-reduction of the stored result (odd number of ones).
- Storage is a 2-entry FIFO (head/tail registers with a 2-bit occupancy counter, values 0..2). o_result and o_status are driven from the head register only; no combinational path from i_result.
- Occupancy update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged; the head advances and the new entry is written behind it.
- o_err_cnt increments by 1 on each push with i_error=1. It saturates at 2**CNT_BITS−1 and does not wrap. It is not affected by pops.
- States are encoded by occupancy:
  - EMPTY(0) → ONE on push.
  - ONE → EMPTY on pop without push.
  - ONE → FULL on push without pop.
  - ONE → ONE on push+pop.
  - FULL → ONE on pop.
  - FULL with i_valid=1: no push, because o_ready=0.
- i_result and i_error are ignored whenever no push occurs.

## Timing
- Reset values (cycle after i_rst sampled high):
  - o_valid=0, o_ready=1, o_result='0, o_status=4'b0000, o_err_cnt=0, occupancy=0.
- Reset mid-operation: all buffered entries are discarded. A push or pop in the same cycle as i_rst=1 has no effect.
- Latency: a push into EMPTY at edge N gives o_valid=1 with the data after edge N. Data is visible in the same cycle as o_valid; there is no extra bubble.
- Throughput: 1 entry/cycle when i_ready is held high.
- o_ready drops the cycle after occupancy reaches 2 and rises the cycle after a pop from FULL. The skid entry covers upstream reacting one cycle late.
- Outputs are stable while o_valid=1 && i_ready=0. A head entry is never overwritten before it is popped.
- Pop from EMPTY cannot occur (o_valid=0); i_ready is ignored there.
- o_err_cnt changes at the same edge as the erroneous push.

## Test plan
- Reset then idle:
  - Stimulus: hold i_rst=1 for 2 cycles, then release; i_valid=0 for 3 cycles.
  - Required: o_valid=0, o_ready=1, o_status=0, o_err_cnt=0 throughout.
- Single pass-through:
  - Stimulus: i_result=32'h0000_0004, i_error=0, i_valid=1 for one cycle, i_ready=1.
  - Required on the next cycle: o_valid=1, o_result=32'h4, o_status=4'b1000 (PAR=1). The following cycle o_valid=0.
- Error entry:
  - Stimulus: i_result=32'hFFFF_FFFF, i_error=1 pushed.
  - Required: o_result=0, o_status=4'b0101 (ERR, ZERO), o_err_cnt=1.
- Backpressure/fill:
  - Stimulus: i_ready=0; push 32'h8000_0001 then 32'h0000_0003; keep i_valid=1.
  - Required: o_ready=0 after the 2nd push; a 3rd value is not accepted. Head shows 32'h8000_0001 with NEG=1, PAR=0.
  - Stimulus: then i_ready=1 for 2 cycles.
  - Required: pops in order 32'h8000_0001, 32'h3; o_ready returns to 1.
- Simultaneous push/pop at occupancy 1:
  - Stimulus: stream 0x1, 0x2, 0x3 on consecutive cycles with i_ready=1.
  - Required: outputs 0x1, 0x2, 0x3 on consecutive cycles; o_ready never deasserts.
- Counter saturation and reset:
  - Stimulus: with CNT_BITS=2, push 5 error entries.
  - Required: o_err_cnt=3.
  - Stimulus: assert i_rst=1 while FULL.
  - Required: next cycle o_valid=0, o_err_cnt=0, o_ready=1.
